ram_be_ctrl: RTL and testbench
==============================

// Module: ram_be_ctrl
// PURPOSE
//   Parametrised single-port RAM with byte-enable writes and a valid/ready request port.
//   Read latency is configurable. A hardware init/clear sequencer fills every word with
//   INIT_VALUE after reset and on a clear command.
//   Successor to the plain 32-bit ram; it is the local buffer store in the CDC datapath.
// PARAMETERS
//   DEPTH         256             number of words, any value >= 2
//   DATA_WIDTH    32              word width in bits, must be a multiple of 8
//   ADDR_WIDTH    $clog2(DEPTH)   address width
//   READ_LATENCY  1               clock edges from read accept to rsp_valid; 1 or 2 only
//   INIT_VALUE    '0              value written to every word by init/clear
// PORTS
//   clk        in   1             clock, rising edge
//   reset      in   1             asynchronous, active-low reset
//   req_valid  in   1             request present
//   req_ready  out  1             block can accept a request this cycle
//   req_write  in   1             1 = write, 0 = read
//   req_addr   in   ADDR_WIDTH    word address
//   req_wdata  in   DATA_WIDTH    write data
//   req_be     in   DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i]
//   rsp_valid  out  1             read data valid, one-cycle pulse per read
//   rsp_rdata  out  DATA_WIDTH    read data
//   rsp_err    out  1             qualifies rsp_valid: the read address was >= DEPTH
//   clear      in   1             start a re-clear of the whole array
//   init_done  out  1             1 = array initialised and the block is in ST_IDLE
// BEHAVIOUR
//   Reset asserted (async):
//     - FSM goes to ST_INIT and init_cnt goes to 0.
//     - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_done = 0.
//     - The read pipeline is flushed. Array contents are not reset directly.
//   ST_INIT:
//     - Each edge writes INIT_VALUE to word init_cnt, then init_cnt increments.
//     - The edge that writes word DEPTH-1 moves the FSM to ST_IDLE.
//     - Therefore req_ready and init_done rise after exactly DEPTH edges following reset release.
//   ST_IDLE:
//     - req_ready = 1. A request is accepted on an edge where req_valid && req_ready.
//     - Write: each byte with req_be set is updated at the accept edge; other bytes are kept.
//       be = 0 is accepted and is a no-op. Writes produce no response.
//     - Read: rsp_valid pulses high for one cycle, READ_LATENCY edges after the accept edge.
//       rsp_rdata holds the word value as of the accept edge. Back-to-back reads give
//       back-to-back responses in order.
//     - Read after write to the same address, on the next cycle, returns the new data.
//       Single port: at most one operation per cycle.
//     - rsp_rdata holds its last value while rsp_valid = 0.
//   Out of range (req_addr >= DEPTH, possible when DEPTH is not a power of 2):
//     - Write is dropped.
//     - Read responds with rsp_rdata = 0 and rsp_err = 1; otherwise rsp_err = 0.
//   clear:
//     - Sampled only in ST_IDLE; ignored in ST_INIT.
//     - A request accepted on the same edge as clear completes normally.
//     - Next state is ST_INIT with init_cnt = 0; req_ready and init_done drop the following cycle.
//     - Reads already in the pipeline still respond with pre-clear data.
//   No response backpressure: the consumer must take rsp_* in the cycle it is presented.
//   Reset mid-init or mid-read: everything restarts from ST_INIT and no pending response is emitted.
// STRUCTURE
//   Package ram_pkg holds:
//     - typedef enum logic {ST_INIT, ST_IDLE} ram_state_t
//     - localparam MIN_READ_LATENCY = 1, MAX_READ_LATENCY = 2
//     - function be_merge(old, wdata, be) for the byte-lane merge
//   Sub-module ram_array: storage, per-byte write, registered read port (latency 1), no reset.
//   ram_be_ctrl holds the FSM, init counter, range check, request mux (init vs user),
//   and the optional second output stage.
//   Elaboration check: DATA_WIDTH % 8 == 0 and READ_LATENCY in {1, 2}.
// TESTING (DEPTH=256, DATA_WIDTH=32, INIT_VALUE=0; run both READ_LATENCY values)
//   1. Release reset and count edges: req_ready/init_done = 0 for 256 edges, then 1.
//      Read addr 0..7 -> rdata = 0.
//   2. Write addr 0 = A5A5A5A5 with be=F, then read addr 0 -> rsp_valid after READ_LATENCY,
//      rdata = A5A5A5A5, err = 0.
//   3. Write addr 1 = 5A5A5A5A with be=F, then write 11223344 with be=0101b, then read
//      -> 5A225A44. A be=0 write leaves the word unchanged.
//   4. Write addr 2 = 1 then read addr 2 on the next cycle; then reads of addr 0, 1, 2 on
//      consecutive cycles -> 3 consecutive rsp_valid pulses in order, no gaps.
//   5. Pulse clear while the addr-0 read is in flight -> that read returns A5A5A5A5;
//      req_ready low for 256 edges; afterwards reads of addr 0 and 1 return 0.
//   6. Assert reset during init and during a pending read -> rsp_valid stays 0 and the
//      init count restarts at 0.
//      With DEPTH=200: write addr 250 is dropped; read addr 250 -> rdata 0, err 1.

Source files
------------

// File: rtl/ram_be_ctrl_pkg.sv
// Shared types for the byte-enable RAM: FSM states, latency bounds, byte-lane merge.
// Pure declarations; no latency or flow control of its own.
package ram_pkg;

    typedef enum logic {ST_INIT, ST_IDLE} ram_state_t;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 2;
    localparam int MAX_DATA_WIDTH   = 512;
    localparam int MAX_BE_WIDTH     = MAX_DATA_WIDTH / 8;

    // Callers zero-extend to the max width and truncate the result back down.
    function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
        input logic [MAX_DATA_WIDTH-1:0] old,
        input logic [MAX_DATA_WIDTH-1:0] wdata,
        input logic [MAX_BE_WIDTH-1:0]   be
    );
        logic [MAX_DATA_WIDTH-1:0] res;
        res = old;
        for (int i = 0; i < MAX_BE_WIDTH; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_be_ctrl_if.sv
// Request/response bundle of the byte-enable RAM: valid/ready request, pulsed response.
// Responses carry no ready; the consumer must take them in the cycle they appear.
interface ram_be_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_be_ctrl_array.sv
// Storage for ram_be_ctrl: per-byte write, registered read (1 cycle), no reset.
// No flow control; the controller guarantees at most one in-range access per cycle.
module ram_array
    import ram_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic                    re_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= DATA_WIDTH'(be_merge(MAX_DATA_WIDTH'(mem_q[addr_i]),
                                                  MAX_DATA_WIDTH'(wdata_i),
                                                  MAX_BE_WIDTH'(be_i)));
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ram_be_ctrl.sv
// Byte-enable RAM controller: init/clear sequencer, range check, 1- or 2-cycle read path.
// req_ready is low while the array is being filled; responses cannot be stalled.
module ram_be_ctrl
    import ram_pkg::*;
#(
    parameter int                    DEPTH        = 256,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = $clog2(DEPTH),
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    output logic          init_done_o,
    ram_be_ctrl_if.slave  bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DATA_WIDTH || DEPTH < 2 ||
        READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_cfg
        $error("ram_be_ctrl: illegal parameter combination");
    end

    ram_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  accept, in_range, rd_acc;
    logic                  arr_we, arr_re;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata, s1_dat;
    logic [BE_WIDTH-1:0]   arr_be;
    logic                  v1_q, err1_q;

    assign in_range = {1'b0, bus.req_addr} < (ADDR_WIDTH+1)'(DEPTH);
    assign rd_acc   = accept && !bus.req_write;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        accept        = 1'b0;
        arr_we        = 1'b0;
        arr_re        = 1'b0;
        arr_addr      = bus.req_addr;
        arr_wdata     = bus.req_wdata;
        arr_be        = bus.req_be;
        bus.req_ready = 1'b0;
        init_done_o   = 1'b0;
        case (state_q)
            ST_INIT: begin
                arr_we     = 1'b1;
                arr_addr   = init_cnt_q;
                arr_wdata  = INIT_VALUE;
                arr_be     = '1;
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                init_done_o   = 1'b1;
                accept        = bus.req_valid;
                arr_we        = accept && bus.req_write && in_range;
                arr_re        = accept && !bus.req_write && in_range;
                // A request accepted alongside clear still completes this edge.
                if (clear_i) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    ram_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .be_i    (arr_be),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q   <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            v1_q   <= rd_acc;
            err1_q <= rd_acc && !in_range;
        end
    end

    assign s1_dat = err1_q ? '0 : arr_rdata;

    if (READ_LATENCY == MAX_READ_LATENCY) begin : g_lat2
        logic                  v2_q, err2_q;
        logic [DATA_WIDTH-1:0] d2_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v2_q   <= 1'b0;
                err2_q <= 1'b0;
                d2_q   <= '0;
            end else begin
                v2_q   <= v1_q;
                err2_q <= v1_q && err1_q;
                if (v1_q) d2_q <= s1_dat;
            end
        end

        assign bus.rsp_valid = v2_q;
        assign bus.rsp_err   = err2_q;
        assign bus.rsp_rdata = d2_q;
    end else begin : g_lat1
        // The array register is unreset, so the visible data is held separately.
        logic [DATA_WIDTH-1:0] hold_q;
        logic [DATA_WIDTH-1:0] rdata;

        assign rdata = v1_q ? s1_dat : hold_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) hold_q <= '0;
            else         hold_q <= rdata;
        end

        assign bus.rsp_valid = v1_q;
        assign bus.rsp_err   = v1_q && err1_q;
        assign bus.rsp_rdata = rdata;
    end
endmodule

// File: tb/tb_ram_be_ctrl.sv
// Bench for ram_be_ctrl: latency-1 and latency-2 instances at DEPTH 256 plus a DEPTH 200 instance.
module tb_ram_be_ctrl;
    typedef struct {
        bit          to3;
        bit          w;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] ed;
        bit          ee;
        bit          clr;
    } op_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, write, sel3, clear;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        done0, done1, done2;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sbq [3][$];
    op_t  tbl [$];

    logic        rdy_w [3];
    logic        rv_w  [3];
    logic        re_w  [3];
    logic        dn_w  [3];
    logic [31:0] rd_w  [3];
    logic [31:0] last_rd [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_be_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if0 ();
    ram_be_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if1 ();
    ram_be_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if2 ();

    assign if0.req_valid = valid & ~sel3;
    assign if1.req_valid = valid & ~sel3;
    assign if2.req_valid = valid & sel3;
    assign if0.req_write = write; assign if1.req_write = write; assign if2.req_write = write;
    assign if0.req_addr  = addr;  assign if1.req_addr  = addr;  assign if2.req_addr  = addr;
    assign if0.req_wdata = wdata; assign if1.req_wdata = wdata; assign if2.req_wdata = wdata;
    assign if0.req_be    = be;    assign if1.req_be    = be;    assign if2.req_be    = be;

    assign rdy_w[0] = if0.req_ready; assign rdy_w[1] = if1.req_ready; assign rdy_w[2] = if2.req_ready;
    assign rv_w[0]  = if0.rsp_valid; assign rv_w[1]  = if1.rsp_valid; assign rv_w[2]  = if2.rsp_valid;
    assign re_w[0]  = if0.rsp_err;   assign re_w[1]  = if1.rsp_err;   assign re_w[2]  = if2.rsp_err;
    assign rd_w[0]  = if0.rsp_rdata; assign rd_w[1]  = if1.rsp_rdata; assign rd_w[2]  = if2.rsp_rdata;
    assign dn_w[0]  = done0;         assign dn_w[1]  = done1;         assign dn_w[2]  = done2;

    ram_be_ctrl #(.DEPTH(256), .DATA_WIDTH(32), .READ_LATENCY(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear & ~sel3), .init_done_o(done0), .bus(if0));
    ram_be_ctrl #(.DEPTH(256), .DATA_WIDTH(32), .READ_LATENCY(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear & ~sel3), .init_done_o(done1), .bus(if1));
    ram_be_ctrl #(.DEPTH(200), .DATA_WIDTH(32), .READ_LATENCY(1)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear & sel3), .init_done_o(done2), .bus(if2));

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    function automatic op_t wr(bit to3, logic [7:0] a, logic [31:0] wd, logic [3:0] b);
        op_t o;
        o = '{to3, 1'b1, a, wd, b, 32'h0, 1'b0, 1'b0};
        return o;
    endfunction

    function automatic op_t rd(bit to3, logic [7:0] a, logic [31:0] ed, bit ee);
        op_t o;
        o = '{to3, 1'b0, a, 32'h0, 4'h0, ed, ee, 1'b0};
        return o;
    endfunction

    // Response scoreboard: every response must match the queue head at its due cycle.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                last_rd[k] = '0;
            end else if (rv_w[k]) begin
                if (sbq[k].size() == 0) begin
                    chk("unexpected_rsp", k, 32'(rv_w[k]), 32'd0);
                end else begin
                    exp_t e;
                    e = sbq[k].pop_front();
                    chk("rsp_rdata", k, rd_w[k], e.dat);
                    chk("rsp_err", k, 32'(re_w[k]), 32'(e.err));
                    chk("rsp_cycle", k, 32'(cyc), 32'(e.due));
                end
                last_rd[k] = rd_w[k];
            end else begin
                chk("rdata_hold", k, rd_w[k], last_rd[k]);
                chk("err_idle", k, 32'(re_w[k]), 32'd0);
                if (sbq[k].size() != 0 && sbq[k][0].due < cyc) begin
                    chk("missing_rsp", k, 32'(rv_w[k]), 32'd1);
                    void'(sbq[k].pop_front());
                end
            end
        end
    end

    task automatic drive(input op_t o);
        @(negedge clk);
        sel3 = o.to3; valid = 1'b1; write = o.w; addr = o.a;
        wdata = o.wd; be = o.be; clear = o.clr;
        if (o.to3) begin
            chk("req_ready", 2, 32'(rdy_w[2]), 32'd1);
            if (!o.w) sbq[2].push_back('{o.ed, o.ee, cyc + 1});
        end else begin
            chk("req_ready", 0, 32'(rdy_w[0]), 32'd1);
            chk("req_ready", 1, 32'(rdy_w[1]), 32'd1);
            if (!o.w) begin
                sbq[0].push_back('{o.ed, o.ee, cyc + 1});
                sbq[1].push_back('{o.ed, o.ee, cyc + 2});
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0; clear = 1'b0; sel3 = 1'b0;
    endtask

    task automatic chk_reset_state();
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", k, 32'(rdy_w[k]), 32'd0);
            chk("rst_valid", k, 32'(rv_w[k]), 32'd0);
            chk("rst_rdata", k, rd_w[k], 32'd0);
            chk("rst_err", k, 32'(re_w[k]), 32'd0);
            chk("rst_done", k, 32'(dn_w[k]), 32'd0);
        end
    endtask

    // Counts edges from the next posedge until req_ready rises on each selected instance.
    task automatic count_ready(input bit [2:0] mask, input int e0, input int e1, input int e2);
        int first [3];
        int want  [3];
        first = '{0, 0, 0};
        want  = '{e0, e1, e2};
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++)
                if (mask[k] && first[k] == 0 && rdy_w[k]) first[k] = n;
            if ((!mask[0] || first[0] != 0) && (!mask[1] || first[1] != 0) &&
                (!mask[2] || first[2] != 0)) break;
        end
        for (int k = 0; k < 3; k++) begin
            if (mask[k]) begin
                chk("init_edges", k, 32'(first[k]), 32'(want[k]));
                chk("init_done", k, 32'(dn_w[k]), 32'd1);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        op_t clr_op;
        rst_n = 1'b0; valid = 1'b0; write = 1'b0; sel3 = 1'b0; clear = 1'b0;
        addr = '0; wdata = '0; be = '0;

        for (int i = 0; i < 8; i++) tbl.push_back(rd(1'b0, 8'(i), 32'h0, 1'b0));
        tbl.push_back(wr(1'b0, 8'd0, 32'hA5A5A5A5, 4'hF));
        tbl.push_back(rd(1'b0, 8'd0, 32'hA5A5A5A5, 1'b0));
        tbl.push_back(wr(1'b0, 8'd1, 32'h5A5A5A5A, 4'hF));
        tbl.push_back(wr(1'b0, 8'd1, 32'h11223344, 4'b0101));
        tbl.push_back(rd(1'b0, 8'd1, 32'h5A225A44, 1'b0));
        tbl.push_back(wr(1'b0, 8'd1, 32'hFFFFFFFF, 4'h0));
        tbl.push_back(rd(1'b0, 8'd1, 32'h5A225A44, 1'b0));
        tbl.push_back(wr(1'b0, 8'd2, 32'h00000001, 4'hF));
        tbl.push_back(rd(1'b0, 8'd2, 32'h00000001, 1'b0));
        tbl.push_back(rd(1'b0, 8'd0, 32'hA5A5A5A5, 1'b0));
        tbl.push_back(rd(1'b0, 8'd1, 32'h5A225A44, 1'b0));
        tbl.push_back(rd(1'b0, 8'd2, 32'h00000001, 1'b0));
        tbl.push_back(wr(1'b0, 8'd3, 32'hDEADBEEF, 4'b1010));
        tbl.push_back(rd(1'b0, 8'd3, 32'hDE00BE00, 1'b0));
        tbl.push_back(wr(1'b1, 8'd250, 32'hFFFFFFFF, 4'hF));
        tbl.push_back(rd(1'b1, 8'd250, 32'h0, 1'b1));
        tbl.push_back(rd(1'b1, 8'd50, 32'h0, 1'b0));
        tbl.push_back(wr(1'b1, 8'd199, 32'h12345678, 4'hF));
        tbl.push_back(rd(1'b1, 8'd199, 32'h12345678, 1'b0));
        tbl.push_back(rd(1'b1, 8'd250, 32'h0, 1'b1));

        repeat (3) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;
        count_ready(3'b111, 256, 256, 200);

        foreach (tbl[i]) drive(tbl[i]);
        idle();
        repeat (4) @(negedge clk);

        // Clear together with a read of addr 0: the read still returns pre-clear data.
        clr_op = rd(1'b0, 8'd0, 32'hA5A5A5A5, 1'b0);
        clr_op.clr = 1'b1;
        drive(clr_op);
        @(posedge clk); #1;
        chk("clear_ready_drop", 0, 32'(rdy_w[0]), 32'd0);
        chk("clear_ready_drop", 1, 32'(rdy_w[1]), 32'd0);
        chk("clear_done_drop", 0, 32'(dn_w[0]), 32'd0);
        chk("dut2_unaffected", 2, 32'(rdy_w[2]), 32'd1);
        idle();
        count_ready(3'b011, 256, 256, 0);
        drive(rd(1'b0, 8'd0, 32'h0, 1'b0));
        drive(rd(1'b0, 8'd1, 32'h0, 1'b0));
        idle();
        repeat (4) @(negedge clk);

        // Reset in the middle of initialisation restarts the count.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        count_ready(3'b111, 256, 256, 200);

        // Reset while the latency-2 read is still in its pipeline.
        drive(wr(1'b0, 8'd5, 32'hCAFEF00D, 4'hF));
        drive(rd(1'b0, 8'd5, 32'hCAFEF00D, 1'b0));
        @(posedge clk); #2;
        rst_n = 1'b0;
        valid = 1'b0;
        sbq[1].delete();
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_pending_valid", 1, 32'(rv_w[1]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) chk("post_rst_valid", k, 32'(rv_w[k]), 32'd0);
        end
        count_ready(3'b111, 252, 252, 196);

        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) chk("sb_drain", k, 32'(sbq[k].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
